mem_burst_seq: RTL
==================

# mem_burst_seq

Burst sequencer between `memory_control` and the SDRAM command controller. It turns a level request (`C_READ` or `C_WRITE` with bank and row address) into a series of fixed-length SDRAM bursts. It generates the per-word `BUF_EN` strobes that move data through `memory_control`'s line buffers, and pulses `END_OPERATION` once the whole row operation has completed.

## Interface
Parameters:
- `WORDS_PER_OP`, 1024: words per row operation; must be a multiple of `BURST_LEN`.
- `BURST_LEN`, 8: words per SDRAM burst; power of two, 2..16.
- `COL_WIDTH`, 9: SDRAM column address bits.

Ports:
- `CLK100` in 1: single clock, all logic on its rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `C_READ` in 1: read-row request, level.
- `C_WRITE` in 1: write-row request, level.
- `C_BANK` in 2: bank of the request.
- `C_ROW_ADDRESS` in 13: start row of the request.
- `DATA_MEM_OUT` in 16: write word from `memory_control`, valid the cycle after `BUF_EN`.
- `DATA_MEM_IN` out 16: read word to `memory_control`, registered.
- `BUF_EN` out 1: one pulse per word moved, registered.
- `END_OPERATION` out 1: one-cycle completion pulse.
- `BUSY` out 1: high whenever the sequencer is not in IDLE.
- `SD_CMD_VALID` out 1: burst command valid.
- `SD_CMD_READY` in 1: controller accepts the command.
- `SD_WE` out 1: 1 = write burst, 0 = read burst.
- `SD_ADDR` out 2+13+`COL_WIDTH`: `{bank,row,col}` of the burst's first word.
- `SD_WDATA` out 16: write word.
- `SD_WREADY` in 1: controller consumes the current `SD_WDATA`.
- `SD_RDATA` in 16: read word.
- `SD_RVALID` in 1: `SD_RDATA` is valid.

## Operation
- State machine states: IDLE, W_FILL, W_CMD, W_DATA, R_CMD, R_DATA, DONE.
- IDLE → W_FILL when `C_WRITE`=1 and `C_READ`=0.
- IDLE → R_CMD when `C_READ`=1 and `C_WRITE`=0.
- Both request lines high: no request; stay in IDLE.
- On leaving IDLE, latch direction, `C_BANK` and `C_ROW_ADDRESS`, and clear word counter `w`. Request inputs are ignored until DONE, so a request that drops mid-operation still completes.
- Burst address:
  - col = `w` mod 2^`COL_WIDTH`.
  - row = latched row + (`w` >> `COL_WIDTH`), 13-bit, wraps modulo 8192.
  - bank = latched bank.
- W_FILL:
  - `BUF_EN`=1 for `BURST_LEN` consecutive cycles.
  - `DATA_MEM_OUT` is captured into an internal `BURST_LEN`×16 buffer one cycle after each `BUF_EN`.
  - Go to W_CMD on the cycle after the last capture.
- W_CMD: `SD_CMD_VALID`=1, `SD_WE`=1, `SD_ADDR` stable; go to W_DATA on `SD_CMD_VALID`&`SD_CMD_READY`.
- W_DATA:
  - `SD_WDATA` = buf[idx].
  - idx advances on each `SD_WREADY`.
  - After `BURST_LEN` words: `w` += `BURST_LEN`, then go to DONE if `w`=`WORDS_PER_OP`, else W_FILL.
- R_CMD: as W_CMD with `SD_WE`=0; go to R_DATA on handshake.
- R_DATA:
  - On each `SD_RVALID`, register `DATA_MEM_IN`<=`SD_RDATA` and `BUF_EN`<=1 for the following cycle.
  - After `BURST_LEN` words: `w` += `BURST_LEN`, then go to DONE or R_CMD.
  - `SD_RVALID` outside R_DATA is ignored.
- DONE: `END_OPERATION`=1 for exactly one cycle, then go to IDLE. IDLE samples the requests no earlier than the cycle after DONE.
- Async reset, at any point including mid-burst:
  - State → IDLE; counters and buffer index cleared.
  - Outputs: `BUF_EN`=0, `END_OPERATION`=0, `BUSY`=0, `SD_CMD_VALID`=0, `SD_WE`=0, `SD_ADDR`=0, `SD_WDATA`=0, `DATA_MEM_IN`=0.

## Timing
- Request to first `BUF_EN` (write): 1 cycle after the request is sampled in IDLE.
- Request to `SD_CMD_VALID` (read): 1 cycle after the request is sampled in IDLE.
- Write fill: `BURST_LEN`+1 cycles per burst.
- Command: held until ready; minimum 1 cycle.
- `SD_CMD_VALID`, `SD_ADDR` and `SD_WE` must stay stable while not accepted.
- `SD_RVALID` to `BUF_EN`/`DATA_MEM_IN`: 1 cycle.
- Read completion: `END_OPERATION` rises in the cycle after the last `BUF_EN`.
- Write completion: `END_OPERATION` rises in the cycle after the last `SD_WREADY` handshake.
- Minimum spacing between two operations: END cycle + 1 IDLE cycle.
- `memory_control` switches its request on the negative edge following `END_OPERATION`.

## Test plan
- Write, `WORDS_PER_OP`=16, `BURST_LEN`=8, bank 1, row 0x0004, ready always 1:
  - Exactly 16 `BUF_EN` pulses.
  - Two commands, `SD_ADDR` = `{1,0x0004,0}` then `{1,0x0004,8}`.
  - `SD_WDATA` sequence equals the `DATA_MEM_OUT` sequence.
  - One `END_OPERATION` pulse.
- Read, `WORDS_PER_OP`=1024, `COL_WIDTH`=9, row 0x1FFF:
  - Burst 64 is addressed at row 0x0000, col 0 (wrap).
  - 1024 `BUF_EN` pulses, each 1 cycle after `SD_RVALID`, with matching `DATA_MEM_IN`.
- `SD_CMD_READY` held low for 5 cycles:
  - `SD_CMD_VALID`, `SD_ADDR` and `SD_WE` are unchanged over those cycles.
  - Transfer proceeds after ready rises.
- `C_READ` drops mid-operation, then `C_WRITE` rises: read completes with all words and `END_OPERATION`; the write starts only after the IDLE cycle.
- `C_READ`=`C_WRITE`=1 for 10 cycles: `BUSY`=0, no command, no `BUF_EN`.
- `RESET_N` pulled low during W_DATA:
  - All outputs 0 immediately.
  - After release, a new write starts cleanly at `w`=0.

Source files
------------

// File: rtl/mem_burst_seq.sv
// Burst sequencer: splits a row read/write request from memory_control into
// fixed-length SDRAM bursts and strobes the line buffers one word at a time.
module mem_burst_seq #(
  parameter int WORDS_PER_OP = 1024,
  parameter int BURST_LEN    = 8,
  parameter int COL_WIDTH    = 9
) (
  input  logic                      CLK100,
  input  logic                      RESET_N,
  input  logic                      C_READ,
  input  logic                      C_WRITE,
  input  logic [1:0]                C_BANK,
  input  logic [12:0]               C_ROW_ADDRESS,
  input  logic [15:0]               DATA_MEM_OUT,
  output logic [15:0]               DATA_MEM_IN,
  output logic                      BUF_EN,
  output logic                      END_OPERATION,
  output logic                      BUSY,
  output logic                      SD_CMD_VALID,
  input  logic                      SD_CMD_READY,
  output logic                      SD_WE,
  output logic [2+13+COL_WIDTH-1:0] SD_ADDR,
  output logic [15:0]               SD_WDATA,
  input  logic                      SD_WREADY,
  input  logic [15:0]               SD_RDATA,
  input  logic                      SD_RVALID
);

  localparam int CNT_W  = $clog2(WORDS_PER_OP + 1);
  localparam int SLOT_W = $clog2(BURST_LEN);
  localparam int IDX_W  = SLOT_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(BURST_LEN);

  typedef enum logic [2:0] {IDLE, W_FILL, W_CMD, W_DATA, R_CMD, R_DATA, DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_bank;
  logic [12:0]          r_row;
  logic [CNT_W-1:0]     r_w;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_buf_en;
  logic [15:0]          r_data_in;
  logic [15:0]          r_buf [BURST_LEN];

  logic                 w_latch;
  logic                 w_idx_clr;
  logic                 w_idx_inc;
  logic                 w_w_adv;
  logic                 w_fill_cap;
  logic                 w_rd_cap;
  logic                 w_buf_en_nxt;
  logic                 w_last_burst;
  logic [SLOT_W-1:0]    w_fill_slot;
  logic [12:0]          w_row;
  logic [COL_WIDTH-1:0] w_col;

  assign w_last_burst = (32'(r_w) + 32'(BURST_LEN)) == 32'(WORDS_PER_OP);
  assign w_fill_slot  = SLOT_W'(r_idx - IDX_W'(1));

  always_ff @(posedge CLK100 or negedge RESET_N) begin
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // r_idx counts fill cycles in W_FILL (capture lags BUF_EN by one) and words in the data phases.
  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_idx_clr    = 1'b0;
    w_idx_inc    = 1'b0;
    w_w_adv      = 1'b0;
    w_fill_cap   = 1'b0;
    w_rd_cap     = 1'b0;
    w_buf_en_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (C_WRITE && !C_READ) begin
          w_state_nxt  = W_FILL;
          w_latch      = 1'b1;
          w_idx_clr    = 1'b1;
          w_buf_en_nxt = 1'b1;
        end else if (C_READ && !C_WRITE) begin
          w_state_nxt = R_CMD;
          w_latch     = 1'b1;
          w_idx_clr   = 1'b1;
        end
      end
      W_FILL: begin
        w_idx_inc    = 1'b1;
        w_fill_cap   = (r_idx != '0);
        w_buf_en_nxt = (r_idx < IDX_LAST);
        if (r_idx == IDX_FULL) begin
          w_state_nxt = W_CMD;
          w_idx_clr   = 1'b1;
        end
      end
      W_CMD: begin
        if (SD_CMD_READY) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        if (SD_WREADY) begin
          if (r_idx == IDX_LAST) begin
            w_w_adv   = 1'b1;
            w_idx_clr = 1'b1;
            if (w_last_burst) begin
              w_state_nxt = DONE;
            end else begin
              w_state_nxt  = W_FILL;
              w_buf_en_nxt = 1'b1;
            end
          end else begin
            w_idx_inc = 1'b1;
          end
        end
      end
      R_CMD: begin
        if (SD_CMD_READY) w_state_nxt = R_DATA;
      end
      // One extra cycle after the last word so END_OPERATION follows the final BUF_EN.
      R_DATA: begin
        if (r_idx == IDX_FULL) begin
          w_w_adv     = 1'b1;
          w_idx_clr   = 1'b1;
          w_state_nxt = w_last_burst ? DONE : R_CMD;
        end else if (SD_RVALID) begin
          w_rd_cap     = 1'b1;
          w_buf_en_nxt = 1'b1;
          w_idx_inc    = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK100 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_bank    <= '0;
      r_row     <= '0;
      r_w       <= '0;
      r_idx     <= '0;
      r_buf_en  <= 1'b0;
      r_data_in <= '0;
    end else begin
      r_buf_en <= w_buf_en_nxt;
      if (w_latch) begin
        r_bank <= C_BANK;
        r_row  <= C_ROW_ADDRESS;
        r_w    <= '0;
      end else if (w_w_adv) begin
        r_w <= r_w + CNT_W'(BURST_LEN);
      end
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + IDX_W'(1);
      if (w_rd_cap) r_data_in <= SD_RDATA;
    end
  end

  always_ff @(posedge CLK100) begin
    if (w_fill_cap) r_buf[w_fill_slot] <= DATA_MEM_OUT;
  end

  assign w_row = r_row + 13'(32'(r_w) >> COL_WIDTH);
  assign w_col = COL_WIDTH'(r_w);

  assign SD_ADDR       = {r_bank, w_row, w_col};
  assign SD_CMD_VALID  = (r_state == W_CMD) || (r_state == R_CMD);
  assign SD_WE         = (r_state == W_CMD);
  assign SD_WDATA      = (r_state == W_DATA) ? r_buf[r_idx[SLOT_W-1:0]] : '0;
  assign BUF_EN        = r_buf_en;
  assign DATA_MEM_IN   = r_data_in;
  assign END_OPERATION = (r_state == DONE);
  assign BUSY          = (r_state != IDLE);

endmodule
